// File: rtl/mips_pkg.sv
// ==== mips_pkg : opcode and sequencer state definitions -- rev 1.0 ====
`default_nettype none

package mips_pkg;

  localparam int STATE_W = 3;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/pc_sequencer_if.sv
// ==== pc_sequencer_if : instruction/data memory request handshake -- rev 1.0 ====
`default_nettype none

interface pc_sequencer_if;
  logic mem_req;
  logic mem_we;
  logic mem_ready;

  modport master (output mem_req, output mem_we, input mem_ready);
  modport slave  (input mem_req, input mem_we, output mem_ready);
endinterface

`default_nettype wire

// File: rtl/pc_reg.sv
// ==== pc_reg : program counter register, load has priority over increment -- rev 1.0 ====
`default_nettype none

module pc_reg
  import mips_pkg::*;
#(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic            clk,
  input  wire logic            reset,
  input  wire logic            inc,
  input  wire logic            load,
  input  wire logic [PC_W-1:0] d,
  output logic      [PC_W-1:0] q
);

  localparam logic [PC_W-1:0] C_ONE = {{(PC_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end else if (inc) begin
      q <= q + C_ONE;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ==== pc_sequencer : multi-cycle fetch/decode/exec/mem/wb sequencer owning the PC -- rev 1.0 ====
`default_nettype none

module pc_sequencer
  import mips_pkg::*;
#(
  parameter int              PC_W     = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  wire logic              clk,
  input  wire logic              reset,
  input  wire logic [5:0]        opcode,
  input  wire logic              zero,
  input  wire logic [PC_W-1:0]   imm,
  input  wire logic [PC_W-1:0]   jtarget,
  pc_sequencer_if.master         mem,
  output logic      [PC_W-1:0]   pc,
  output logic      [STATE_W-1:0] state,
  output logic                   ir_we,
  output logic                   reg_we,
  output logic                   halted
);

  state_t            r_state;
  state_t            w_next;
  logic [5:0]        r_op;
  logic              w_inc;
  logic              w_load;
  logic [PC_W-1:0]   w_d;
  logic              w_req;
  logic              w_mem_we;
  logic              w_ir_we;
  logic              w_reg_we;
  logic              w_halted;

  pc_reg #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .reset (reset),
    .inc   (w_inc),
    .load  (w_load),
    .d     (w_d),
    .q     (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_FETCH;
      r_op    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_op <= opcode;
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    w_inc    = 1'b0;
    w_load   = 1'b0;
    w_d      = jtarget;
    w_req    = 1'b0;
    w_mem_we = 1'b0;
    w_ir_we  = 1'b0;
    w_reg_we = 1'b0;
    w_halted = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_req = 1'b1;
        if (mem.mem_ready) begin
          w_ir_we = 1'b1;
          w_inc   = 1'b1;
          w_next  = S_DECODE;
        end
      end
      // Decision here uses the live opcode; r_op captures it on this same edge.
      S_DECODE: begin
        case (opcode)
          OP_J: begin
            w_load = 1'b1;
            w_d    = jtarget;
            w_next = S_FETCH;
          end
          OP_HALT:                                  w_next = S_HALT;
          OP_BEQ, OP_RTYPE, OP_ADDI, OP_LW, OP_SW:  w_next = S_EXEC;
          default:                                  w_next = S_FETCH;
        endcase
      end
      S_EXEC: begin
        case (r_op)
          OP_BEQ: begin
            w_load = zero;
            w_d    = pc + imm;
            w_next = S_FETCH;
          end
          OP_LW, OP_SW:      w_next = S_MEM;
          OP_RTYPE, OP_ADDI: w_next = S_WB;
          default:           w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        w_req    = 1'b1;
        w_mem_we = (r_op == OP_SW);
        if (mem.mem_ready) begin
          w_next = (r_op == OP_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        w_reg_we = 1'b1;
        w_next   = S_FETCH;
      end
      S_HALT: begin
        w_halted = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Reset leaves the FSM in FETCH, so strobes are masked while it is held.
  assign mem.mem_req = w_req    & reset;
  assign mem.mem_we  = w_mem_we & reset;
  assign ir_we       = w_ir_we  & reset;
  assign reg_we      = w_reg_we & reset;
  assign halted      = w_halted & reset;
  assign state       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ==== tb_pc_sequencer : randomized self-checking bench for pc_sequencer -- rev 1.0 ====
`default_nettype none

module tb_pc_sequencer;

  localparam logic [5:0] RT = 6'h00;
  localparam logic [5:0] JJ = 6'h02;
  localparam logic [5:0] BQ = 6'h04;
  localparam logic [5:0] AD = 6'h08;
  localparam logic [5:0] LW = 6'h23;
  localparam logic [5:0] SW = 6'h2B;
  localparam logic [5:0] HL = 6'h3F;

  // Phase numbers match the published state encoding.
  localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_H = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic [3:0] imm = '0;
  logic [3:0] jtarget = '0;
  logic [3:0] pc;
  logic [2:0] state;
  logic       ir_we;
  logic       reg_we;
  logic       halted;

  pc_sequencer_if mif();

  pc_sequencer #(
    .PC_W     (4),
    .RESET_PC (4'd0)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .opcode  (opcode),
    .zero    (zero),
    .imm     (imm),
    .jtarget (jtarget),
    .mem     (mif),
    .pc      (pc),
    .state   (state),
    .ir_we   (ir_we),
    .reg_we  (reg_we),
    .halted  (halted)
  );

  always #5 clk = ~clk;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [3:0] m_pc;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] obs();
    return {state, mif.mem_req, mif.mem_we, ir_we, reg_we, halted};
  endfunction

  function automatic bit is_known(input logic [5:0] o);
    return (o == RT) || (o == JJ) || (o == BQ) || (o == AD) ||
           (o == LW) || (o == SW) || (o == HL);
  endfunction

  task automatic release_reset();
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_val("first_req", {30'd0, mif.mem_req, mif.mem_we}, 32'h2);
  endtask

  task automatic async_reset_check(input string tag);
    #1 reset = 1'b0;
    #1;
    check_val({tag, "_state"}, 32'(state), 32'd0);
    check_val({tag, "_pc"}, 32'(pc), 32'd0);
    check_val({tag, "_strobes"}, 32'(obs()), 32'd0);
    m_pc = 4'd0;
    mif.mem_ready = 1'b0;
    release_reset();
  endtask

  // One instruction from the start of FETCH: the expected phase list comes
  // from the cycle-count rules, then every cycle is compared as a whole.
  task automatic run_instr(input logic [5:0] op, input logic z, input logic [3:0] im,
                           input logic [3:0] jt, input int fw, input int mw,
                           input logic [5:0] late_op);
    int         ph[$];
    int         mi;
    int         p;
    logic [3:0] npc;
    logic [7:0] exp_v;
    for (int i = 0; i <= fw; i++) ph.push_back(P_F);
    ph.push_back(P_D);
    case (op)
      BQ:     ph.push_back(P_E);
      RT, AD: begin ph.push_back(P_E); ph.push_back(P_W); end
      LW: begin
        ph.push_back(P_E);
        for (int i = 0; i <= mw; i++) ph.push_back(P_M);
        ph.push_back(P_W);
      end
      SW: begin
        ph.push_back(P_E);
        for (int i = 0; i <= mw; i++) ph.push_back(P_M);
      end
      default: ;
    endcase
    npc = m_pc + 4'd1;
    if (op == JJ) npc = jt;
    if (op == BQ && z) npc = npc + im;

    mi = 0;
    for (int c = 0; c < ph.size(); c++) begin
      p = ph[c];
      @(negedge clk);
      opcode        = (c <= fw + 1) ? op : late_op;
      jtarget       = (c <= fw + 2) ? jt : 4'($urandom);
      imm           = (c <= fw + 2) ? im : 4'($urandom);
      zero          = (p == P_E) ? z : 1'($urandom);
      mif.mem_ready = 1'($urandom);
      if (p == P_F) mif.mem_ready = (c == fw);
      if (p == P_M) begin
        mif.mem_ready = (mi == mw);
        mi++;
      end
      #1;
      if (c == 0) check_val($sformatf("pc_at_fetch op%02h", op), 32'(pc), 32'(m_pc));
      exp_v = {p[2:0], (p == P_F) || (p == P_M), (p == P_M) && (op == SW),
               (p == P_F) && (c == fw), p == P_W, 1'b0};
      check_val($sformatf("cyc%0d op%02h", c, op), 32'(obs()), 32'(exp_v));
    end
    m_pc = npc;

    if (op == HL) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        opcode        = 6'($urandom);
        mif.mem_ready = 1'($urandom);
        zero          = 1'($urandom);
        #1 check_val($sformatf("halt%0d", k), 32'(obs()), {24'd0, 3'(P_H), 5'b00001});
      end
      check_val("halt_pc", 32'(pc), 32'(m_pc));
      async_reset_check("rst_halt");
    end
  endtask

  task automatic reset_in_mem();
    @(negedge clk);
    opcode = SW;
    mif.mem_ready = 1'b1;
    @(negedge clk);
    mif.mem_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1 check_val("in_mem", 32'(obs()), {24'd0, 3'(P_M), 5'b11000});
    async_reset_check("rst_mem");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] o;
    int         r;
    ops = '{RT, BQ, AD, LW, SW, JJ};
    mif.mem_ready = 1'b1;
    m_pc = 4'd0;

    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      #1;
      check_val("rst_pc", 32'(pc), 32'd0);
      check_val("rst_obs", 32'(obs()), 32'd0);
    end
    mif.mem_ready = 1'b0;
    release_reset();

    run_instr(JJ, 1'b0, 4'd0, 4'd15, 0, 0, 6'($urandom));
    run_instr(RT, 1'b0, 4'd0, 4'd0, 3, 0, 6'($urandom));
    run_instr(JJ, 1'b0, 4'd0, 4'd3, 0, 0, 6'($urandom));
    run_instr(BQ, 1'b1, 4'hE, 4'd0, 0, 0, 6'($urandom));
    run_instr(JJ, 1'b0, 4'd0, 4'd3, 0, 0, 6'($urandom));
    run_instr(BQ, 1'b0, 4'hE, 4'd0, 0, 0, 6'($urandom));
    run_instr(JJ, 1'b0, 4'd0, 4'd9, 0, 0, 6'($urandom));
    run_instr(LW, 1'b0, 4'd0, 4'd0, 0, 2, 6'($urandom));
    run_instr(SW, 1'b0, 4'd0, 4'd0, 0, 1, 6'h00);
    run_instr(AD, 1'b0, 4'd0, 4'd0, 1, 0, 6'h2B);
    reset_in_mem();
    run_instr(JJ, 1'b0, 4'd0, 4'd7, 0, 0, 6'($urandom));
    run_instr(HL, 1'b0, 4'd0, 4'd0, 1, 0, 6'($urandom));

    for (int n = 0; n < 80; n++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        o = HL;
      end else if (r <= 2) begin
        o = 6'($urandom);
        while (is_known(o)) o = 6'($urandom);
      end else begin
        o = ops[$urandom_range(0, 5)];
      end
      run_instr(o, 1'($urandom), 4'($urandom), 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 2), 6'($urandom));
    end

    @(negedge clk);
    #1;
    check_val("final_pc", 32'(pc), 32'(m_pc));
    check_val("final_state", 32'(state), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
